uart_rx_core: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync.sv | 24 ++
 rtl/uart_rx_core.sv | 136 +++++++++++++
 tb/tb_uart_rx_core.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, counter sizing helper and line idle level.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Width of a down-counter that must hold values 0..cycles-1.
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input, with selectable reset level.
module uart_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronizes the line, samples mid-bit, and holds each byte in a
// one-entry output register. o_valid is a level; i_ack while o_valid is high frees it.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int CYCLES_PER_BIT = 108,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx_w,
  input  logic                 i_ack,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CNT_W = cnt_width(CYCLES_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 deliver_p;
  logic                 ferr_p;

  uart_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (UART_IDLE_LEVEL)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx_w),
    .o_q     (rx_s)
  );

  // Sampling FSM; deliver_p/ferr_p flag the stop-sample outcome for the output stage.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      deliver_p <= 1'b0;
      ferr_p    <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      deliver_p <= 1'b0;
      ferr_p    <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_s != UART_IDLE_LEVEL) begin
            cnt    <= HALF_M1;
            state  <= RX_START;
            o_busy <= 1'b1;
          end
        end
        RX_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s == UART_IDLE_LEVEL) begin
            state  <= RX_IDLE;
            o_busy <= 1'b0;
          end else begin
            cnt     <= BIT_M1;
            bit_idx <= '0;
            state   <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            cnt     <= BIT_M1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == LAST_IDX) begin
              state <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s == UART_IDLE_LEVEL) begin
            deliver_p <= 1'b1;
            state     <= RX_IDLE;
            o_busy    <= 1'b0;
          end else begin
            ferr_p <= 1'b1;
            state  <= RX_WAIT_IDLE;
          end
        end
        RX_WAIT_IDLE: begin
          // A held-low line (break) must return high before a new start is accepted.
          if (rx_s == UART_IDLE_LEVEL) begin
            state  <= RX_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= RX_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Output register: a delivery always wins over i_ack; overwriting an unacked byte flags overrun.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= ferr_p;
      o_overrun   <= deliver_p & o_valid & ~i_ack;
      if (deliver_p) begin
        o_data  <= shift;
        o_valid <= 1'b1;
      end else if (i_ack) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit, 8 data bits, 2 sync stages.
module tb_uart_rx_core;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic          i_clk   = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_rx_w  = 1'b1;
  logic          i_ack   = 1'b0;
  logic [DB-1:0] o_data;
  logic          o_valid;
  logic          o_frame_err;
  logic          o_overrun;
  logic          o_busy;

  uart_rx_core #(
    .DATA_BITS      (DB),
    .CYCLES_PER_BIT (CPB),
    .SYNC_STAGES    (2)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rx_w      (i_rx_w),
    .i_ack       (i_ack),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [DB-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_deliv = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int valid_rise_cyc = -1;
  int ferr_cyc = -1;
  int ovr_cyc = -1;
  int busy_rise_cyc = -1;
  int busy_fall_cyc = -1;
  logic prev_valid = 1'b0;
  logic prev_busy = 1'b0;
  int ack_mode = 0;  // 0 = low, 1 = held high, 2 = ack each valid

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Output monitor: every byte load is popped against the expected queue.
  always @(negedge i_clk) begin
    logic [DB-1:0] exp_b;
    if ((o_valid && !prev_valid) || o_overrun) begin
      n_deliv++;
      valid_rise_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_byte: got %0h, required no delivery", o_data);
      end else begin
        exp_b = exp_q.pop_front();
        check("deliver_data", o_data, exp_b);
      end
    end
    if (o_frame_err) begin
      n_ferr++;
      ferr_cyc = cyc;
    end
    if (o_overrun) begin
      n_ovr++;
      ovr_cyc = cyc;
    end
    if (o_busy && !prev_busy) busy_rise_cyc = cyc;
    if (!o_busy && prev_busy) busy_fall_cyc = cyc;
    prev_valid = o_valid;
    prev_busy  = o_busy;
  end

  initial begin
    forever begin
      @(negedge i_clk);
      i_ack = (ack_mode == 1) || (ack_mode == 2 && o_valid);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    i_rx_w = b;
    tick(CPB);
  endtask

  task automatic idle(input int n);
    i_rx_w = 1'b1;
    tick(n);
  endtask

  // t0 is the first clock edge that samples the start bit low.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, output int t0);
    t0 = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    drive_bit(stop_b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_frame_err"}, o_frame_err, 0);
    check({tag, "_overrun"}, o_overrun, 0);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [DB-1:0] data;
    logic [DB-1:0] exp_data;
    int            exp_valid_lat;
    int            exp_busy_rise;
    int            exp_busy_fall;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int t0, t0b, d0, f0, v0;

    vecs[0] = '{data: 8'h41, exp_data: 8'h41, exp_valid_lat: 155, exp_busy_rise: 2, exp_busy_fall: 154};
    vecs[1] = '{data: 8'h80, exp_data: 8'h80, exp_valid_lat: 155, exp_busy_rise: 2, exp_busy_fall: 154};
    vecs[2] = '{data: 8'h01, exp_data: 8'h01, exp_valid_lat: 155, exp_busy_rise: 2, exp_busy_fall: 154};
    vecs[3] = '{data: 8'hC3, exp_data: 8'hC3, exp_valid_lat: 155, exp_busy_rise: 2, exp_busy_fall: 154};

    i_rst_n = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    i_rst_n = 1'b1;
    idle(4);

    // Single frames with i_ack held high.
    ack_mode = 1;
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back(vecs[v].exp_data);
      d0 = n_deliv; f0 = n_ferr; v0 = n_ovr;
      send_frame(vecs[v].data, 1'b1, t0);
      idle(20);
      check("vec_deliveries", n_deliv - d0, 1);
      check("vec_valid_latency", valid_rise_cyc - t0, vecs[v].exp_valid_lat);
      check("vec_busy_rise", busy_rise_cyc - t0, vecs[v].exp_busy_rise);
      check("vec_busy_fall", busy_fall_cyc - t0, vecs[v].exp_busy_fall);
      check("vec_frame_err", n_ferr - f0, 0);
      check("vec_overrun", n_ovr - v0, 0);
      check("vec_valid_cleared", o_valid, 0);
    end

    // Back-to-back 0x00 then 0xFF, no idle gap, acked on each valid.
    ack_mode = 2;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    d0 = n_deliv; f0 = n_ferr; v0 = n_ovr;
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t0b);
    idle(20);
    check("b2b_deliveries", n_deliv - d0, 2);
    check("b2b_second_latency", valid_rise_cyc - t0b, 155);
    check("b2b_frame_err", n_ferr - f0, 0);
    check("b2b_overrun", n_ovr - v0, 0);

    // Four-cycle glitch: false start, back to IDLE at D+8.
    d0 = n_deliv; f0 = n_ferr;
    t0 = cyc + 1;
    i_rx_w = 1'b0;
    tick(4);
    idle(30);
    check("glitch_busy_rise", busy_rise_cyc - t0, 2);
    check("glitch_busy_fall", busy_fall_cyc - t0, 10);
    check("glitch_deliveries", n_deliv - d0, 0);
    check("glitch_frame_err", n_ferr - f0, 0);

    // Stop bit low, line held low 40 more cycles, then a good frame.
    d0 = n_deliv; f0 = n_ferr;
    send_frame(8'hA5, 1'b0, t0);
    i_rx_w = 1'b0;
    tick(40);
    idle(30);
    check("ferr_pulses", n_ferr - f0, 1);
    check("ferr_pulse_cycle", ferr_cyc - t0, 155);
    check("ferr_deliveries", n_deliv - d0, 0);
    check("ferr_busy_fall", busy_fall_cyc - t0, 202);
    check("ferr_valid", o_valid, 0);
    exp_q.push_back(8'h3C);
    d0 = n_deliv;
    send_frame(8'h3C, 1'b1, t0);
    idle(20);
    check("after_ferr_deliveries", n_deliv - d0, 1);
    check("after_ferr_latency", valid_rise_cyc - t0, 155);

    // Two frames without ack: overrun on the second delivery.
    ack_mode = 0;
    idle(2);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    d0 = n_deliv; v0 = n_ovr;
    send_frame(8'h11, 1'b1, t0);
    idle(10);
    send_frame(8'h22, 1'b1, t0b);
    idle(20);
    check("ovr_deliveries", n_deliv - d0, 2);
    check("ovr_pulses", n_ovr - v0, 1);
    check("ovr_pulse_cycle", ovr_cyc - t0b, 155);
    check("ovr_valid_held", o_valid, 1);
    check("ovr_data", o_data, 8'h22);
    ack_mode = 1;
    tick(1);
    check("ack_clears_valid", o_valid, 0);
    ack_mode = 2;
    idle(4);

    // Reset pulse during data bit 3 of 0x55, then 0x7E.
    d0 = n_deliv; f0 = n_ferr;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    i_rx_w = 1'b0;
    tick(5);
    i_rst_n = 1'b0;
    tick(1);
    check_reset_outputs("midframe_reset");
    i_rst_n = 1'b1;
    idle(200);
    check("reset_no_delivery", n_deliv - d0, 0);
    check("reset_no_frame_err", n_ferr - f0, 0);
    check("reset_idle_busy", o_busy, 0);
    exp_q.push_back(8'h7E);
    d0 = n_deliv;
    send_frame(8'h7E, 1'b1, t0);
    idle(20);
    check("after_reset_deliveries", n_deliv - d0, 1);
    check("after_reset_latency", valid_rise_cyc - t0, 155);

    check("expected_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
